bit_stuff: RTL
==============

BIT_STUFF -- requirements
Module: bit_stuff

Interface
REQ-001 The block SHALL expose these ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, reset; asynchronous, active-low.
- start_stuff, input, 1, single-cycle packet-start pulse from the upstream serializer.
- s_in, input, 1, serial data bit from upstream; its first bit is valid in the start_stuff cycle.
- last_bit, input, 1, high with the final data bit of the packet.
- s_out, output, 1, registered serial bit stream to the NRZI encoder.
- stall, output, 1, upstream SHALL hold s_in/last_bit and not advance in the next cycle.
- start_nrzi, output, 1, packet-start strobe to the NRZI encoder.
- done, output, 1, final-bit strobe to the NRZI encoder.
- busy, output, 1, high whenever state is not IDLE.

Function
REQ-002 The FSM SHALL have three states:
- IDLE: no packet.
- SEND: s_out carries a data bit.
- STUFF: s_out carries an inserted 0.

REQ-003 The block SHALL keep a 3-bit ones_cnt of consecutive 1s on s_out, plus a last_seen flag that is set when the bit now on s_out came with last_bit=1.

REQ-004 IDLE behaviour:
- start_nrzi = start_stuff, combinationally; stall = 0; done = 0.
- On a clock edge with start_stuff=1: s_out <= s_in; ones_cnt <= s_in ? 1 : 0; last_seen <= last_bit; go to SEND.

REQ-005 SEND with ones_cnt==6: stall = 1 and done = 0 that cycle; at the edge, s_out <= 0, ones_cnt <= 0, go to STUFF. This applies even when last_seen=1, so a trailing run of six 1s is always stuffed.

REQ-006 SEND with ones_cnt!=6 and last_seen=1: done = 1 that cycle; at the edge, go to IDLE and clear ones_cnt and last_seen.

REQ-007 SEND with ones_cnt!=6 and last_seen=0: at the edge, s_out <= s_in; ones_cnt <= s_in ? ones_cnt+1 : 0; last_seen <= last_bit; stay in SEND.

REQ-008 STUFF with last_seen=1: done = 1 that cycle; at the edge, go to IDLE.

REQ-009 STUFF with last_seen=0: at the edge, load s_in, ones_cnt and last_seen exactly as in REQ-007 and go to SEND; stall = 0.

REQ-010 start_nrzi SHALL be 0 outside IDLE. start_stuff SHALL be ignored in SEND and STUFF.

REQ-011 stall SHALL be high only in SEND with ones_cnt==6, and SHALL never be high for two consecutive cycles.

REQ-012 Latency: each bit sampled at edge E appears on s_out from E until the next load. Every packet SHALL produce exactly one start_nrzi pulse and exactly one done pulse.

REQ-013 ones_cnt SHALL never exceed 6, and SHALL NOT carry over between packets.

REQ-014 s_out SHALL hold its last value in IDLE.

REQ-015 A single-bit packet (start_stuff and last_bit in the same cycle) SHALL give done in the very next cycle, or a stuff-then-done sequence is impossible since ones_cnt would be at most 1.

Reset
REQ-016 While rst_n=0, asynchronously: state=IDLE, ones_cnt=0, last_seen=0, s_out=0, stall=0, done=0, busy=0. start_nrzi=0 unless start_stuff is asserted.

REQ-017 A reset asserted mid-packet SHALL abort the packet with no done pulse. The first edge after deassertion SHALL honour start_stuff.

Verification
REQ-018 The bench SHALL cover:
- Data 1,0,1,1,0,0,1,0 with last_bit on the 8th bit -> s_out bits in that order, no stall, done in the 8th cycle after start_nrzi, busy for 8 cycles.
- Data 1x8 then 0 (last) -> s_out 1,1,1,1,1,1,0,1,1,0; one stall pulse, in the cycle s_out shows the 6th 1; done with the final 0.
- Data 0,1,1,1,1,1,1 with last on the 7th bit -> s_out 0,1x6,0; done in the STUFF cycle; total 8 s_out bits.
- Data 1x12, last on the 12th -> stuffed 0 after the 6th and the 12th 1; two stall pulses 7 cycles apart; done on the 2nd stuffed 0.
- rst_n low during the 4th bit -> outputs 0 immediately, busy=0, no done; the next start_stuff starts with ones_cnt=0.
- start_stuff pulsed again mid-packet -> ignored, no second start_nrzi; the packet completes unchanged.

Source files
------------

// File: rtl/bit_stuff.sv
// Serial bit stuffer: inserts a 0 after every run of six consecutive 1s on s_out
// and frames each packet with start_nrzi / done strobes for the NRZI encoder.
module bit_stuff (
  input  logic clk,
  input  logic rst_n,
  input  logic start_stuff,
  input  logic s_in,
  input  logic last_bit,
  output logic s_out,
  output logic stall,
  output logic start_nrzi,
  output logic done,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STUFF = 2'd2
  } state_e;

  localparam logic [2:0] MAX_ONES = 3'd6;

  state_e     state_q, state_d;
  logic       s_out_q, s_out_d;
  logic [2:0] ones_cnt_q, ones_cnt_d;
  logic       last_seen_q, last_seen_d;

  // A loaded 1 extends the run, a loaded 0 breaks it. The count only reaches 6
  // in SEND, which always diverts to STUFF before another load, so it cannot exceed 6.
  function automatic logic [2:0] next_cnt(input logic bit_in, input logic [2:0] cnt);
    return bit_in ? cnt + 3'd1 : 3'd0;
  endfunction

  // NOTE: every signal assigned here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    s_out_d     = s_out_q;
    ones_cnt_d  = ones_cnt_q;
    last_seen_d = last_seen_q;
    stall       = 1'b0;
    done        = 1'b0;
    start_nrzi  = 1'b0;

    unique case (state_q)
      IDLE: begin
        start_nrzi = start_stuff;
        if (start_stuff) begin
          s_out_d     = s_in;
          ones_cnt_d  = next_cnt(s_in, 3'd0);
          last_seen_d = last_bit;
          state_d     = SEND;
        end
      end

      SEND: begin
        if (ones_cnt_q == MAX_ONES) begin
          // Stuffing wins over ending, so a trailing run of six 1s is still broken.
          stall      = 1'b1;
          s_out_d    = 1'b0;
          ones_cnt_d = 3'd0;
          state_d    = STUFF;
        end else if (last_seen_q) begin
          done        = 1'b1;
          ones_cnt_d  = 3'd0;
          last_seen_d = 1'b0;
          state_d     = IDLE;
        end else begin
          s_out_d     = s_in;
          ones_cnt_d  = next_cnt(s_in, ones_cnt_q);
          last_seen_d = last_bit;
        end
      end

      STUFF: begin
        if (last_seen_q) begin
          done        = 1'b1;
          ones_cnt_d  = 3'd0;
          last_seen_d = 1'b0;
          state_d     = IDLE;
        end else begin
          s_out_d     = s_in;
          ones_cnt_d  = next_cnt(s_in, ones_cnt_q);
          last_seen_d = last_bit;
          state_d     = SEND;
        end
      end

      default: begin
        ones_cnt_d  = 3'd0;
        last_seen_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_out_q     <= 1'b0;
      ones_cnt_q  <= 3'd0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_out_q     <= s_out_d;
      ones_cnt_q  <= ones_cnt_d;
      last_seen_q <= last_seen_d;
    end
  end

  assign s_out = s_out_q;
  assign busy  = (state_q != IDLE);

endmodule
